// File: rtl/varray_rle_if.sv
// Bus bundle for varray_rle: run writes, random reads and the streaming read engine.
// The master side is the writer/reader client; the slave side is the run-length array itself.
interface varray_rle_if #(
  parameter int unsigned VIRTUAL_ELEMENT_WIDTH = 4,
  parameter int unsigned VIRTUAL_ADDR_BITS     = 16,
  parameter int unsigned RUN_LEN_BITS          = 5
);
  logic                             we;
  logic [VIRTUAL_ADDR_BITS-1:0]     write_addr;
  logic [RUN_LEN_BITS-1:0]          write_addr_len;
  logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_w;
  logic                             wr_err;
  logic                             full;
  logic [VIRTUAL_ADDR_BITS-1:0]     varray_len;
  logic                             re;
  logic [VIRTUAL_ADDR_BITS-1:0]     read_addr;
  logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_r;
  logic                             rd_valid;
  logic                             st_start;
  logic [VIRTUAL_ADDR_BITS-1:0]     st_addr;
  logic [VIRTUAL_ADDR_BITS-1:0]     st_count;
  logic                             st_busy;
  logic                             st_valid;
  logic                             st_ready;
  logic [VIRTUAL_ELEMENT_WIDTH-1:0] st_data;
  logic                             st_done;

  modport master (
    output we, write_addr, write_addr_len, dat_w, re, read_addr,
    output st_start, st_addr, st_count, st_ready,
    input  wr_err, full, varray_len, dat_r, rd_valid,
    input  st_busy, st_valid, st_data, st_done
  );

  modport slave (
    input  we, write_addr, write_addr_len, dat_w, re, read_addr,
    input  st_start, st_addr, st_count, st_ready,
    output wr_err, full, varray_len, dat_r, rd_valid,
    output st_busy, st_valid, st_data, st_done
  );
endinterface

// File: rtl/varray_rle.sv
// Run-length virtual array: a table of appended (base, len, value) runs presenting a sparse vector,
// with a registered random-read port and a valid/ready streaming read engine.
module varray_rle #(
  parameter int unsigned VIRTUAL_ELEMENT_WIDTH = 4,
  parameter int unsigned VIRTUAL_ADDR_BITS     = 16,
  parameter int unsigned RUN_LEN_BITS          = 5,
  parameter int unsigned NUM_RUNS              = 8
) (
  input  logic         clk,
  input  logic         reset,
  varray_rle_if.slave  bus_io
);
  localparam int unsigned AW   = VIRTUAL_ADDR_BITS;
  localparam int unsigned AW1  = VIRTUAL_ADDR_BITS + 1;
  localparam int unsigned EW   = VIRTUAL_ELEMENT_WIDTH;
  localparam int unsigned LW   = RUN_LEN_BITS;
  localparam int unsigned CntW = $clog2(NUM_RUNS + 1);

  typedef enum logic [0:0] {StIdle, StRun} st_e;

  logic [AW-1:0]       base_q [NUM_RUNS];
  logic [LW-1:0]       len_q  [NUM_RUNS];
  logic [EW-1:0]       val_q  [NUM_RUNS];
  logic [NUM_RUNS-1:0] used_q;
  logic [CntW-1:0]     cnt_q;
  // End of the last run kept one bit wider so a run ending exactly at 2^AW still blocks appends.
  logic [AW:0]         end_q;
  logic                wr_err_q;
  logic [EW-1:0]       dat_r_q;
  logic                rd_valid_q;

  st_e                 state_q;
  logic [AW-1:0]       cur_q;
  logic [AW-1:0]       rem_q;
  logic                done_q;

  logic                full;
  logic                accept;
  logic [AW:0]         wr_end;
  logic [EW-1:0]       rd_val;
  logic [EW-1:0]       st_val;

  function automatic logic in_run(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                  input logic [LW-1:0] l);
    logic [AW:0] a1;
    logic [AW:0] b1;
    a1 = {1'b0, a};
    b1 = {1'b0, b};
    return (a1 >= b1) && (a1 < b1 + AW1'(l));
  endfunction

  assign full   = (cnt_q == CntW'(NUM_RUNS));
  assign wr_end = {1'b0, bus_io.write_addr} + AW1'(bus_io.write_addr_len);
  assign accept = bus_io.we && !full && (bus_io.write_addr_len != '0) &&
                  ({1'b0, bus_io.write_addr} >= end_q) &&
                  (wr_end <= {1'b1, {AW{1'b0}}});

  // Runs never overlap, so OR-ing the matching values is a one-hot select.
  always_comb begin
    rd_val = '0;
    st_val = '0;
    for (int i = 0; i < NUM_RUNS; i++) begin
      if (used_q[i] && in_run(bus_io.read_addr, base_q[i], len_q[i])) rd_val = rd_val | val_q[i];
      if (used_q[i] && in_run(cur_q, base_q[i], len_q[i]))            st_val = st_val | val_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RUNS; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        val_q[i]  <= '0;
      end
      used_q     <= '0;
      cnt_q      <= '0;
      end_q      <= '0;
      wr_err_q   <= 1'b0;
      dat_r_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_err_q   <= bus_io.we && !accept;
      rd_valid_q <= bus_io.re;
      if (bus_io.re) dat_r_q <= rd_val;
      if (accept) begin
        for (int i = 0; i < NUM_RUNS; i++) begin
          if (cnt_q == CntW'(i)) begin
            base_q[i] <= bus_io.write_addr;
            len_q[i]  <= bus_io.write_addr_len;
            val_q[i]  <= bus_io.dat_w;
            used_q[i] <= 1'b1;
          end
        end
        cnt_q <= cnt_q + CntW'(1);
        end_q <= wr_end;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cur_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.st_start) begin
            if (bus_io.st_count != '0) begin
              state_q <= StRun;
              cur_q   <= bus_io.st_addr;
              rem_q   <= bus_io.st_count;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (bus_io.st_ready) begin
            cur_q <= cur_q + AW'(1);
            rem_q <= rem_q - AW'(1);
            if (rem_q == AW'(1)) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.wr_err     = wr_err_q;
  assign bus_io.full       = full;
  assign bus_io.varray_len = end_q[AW-1:0];
  assign bus_io.dat_r      = dat_r_q;
  assign bus_io.rd_valid   = rd_valid_q;
  assign bus_io.st_busy    = (state_q != StIdle);
  assign bus_io.st_valid   = (state_q == StRun);
  assign bus_io.st_data    = st_val;
  assign bus_io.st_done    = done_q;
endmodule
